mux4_port_arbiter: RTL and testbench
====================================

Name: mux4_port_arbiter

Overview:
- Round-robin arbiter that shares one downstream resource among 4 requesters, e.g. the data-memory port or a shared ALU operand path.
- Drives the 2-bit select of the 4:1 datapath mux (Mulfour s1/s0) that steers the winning requester's bus to the resource.
- Sequences each transaction with a valid/done handshake to the resource and returns a per-requester ack or timeout error.
- Sits in the processor top level between the requesting units and the shared port.

Parameters:
- TIMEOUT, 16: max cycles a granted transaction may wait for mem_done before abort; legal range 1 to 2^TW-1.
- TW, 5: width of the timeout counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-low; sampled on rising clk edge.
- req  input  4  per-requester request; must be held high until ack or err for that requester.
- gnt  output 4  one-hot grant; all zero when no transaction is active.
- sel  output 2  mux select to the datapath mux; sel[1] goes to s1, sel[0] goes to s0.
- mem_valid  output 1  transaction active toward the shared resource.
- mem_done  input  1  resource completion; meaningful only while mem_valid=1.
- ack  output 4  one-hot, 1-cycle pulse: transaction completed.
- err  output 4  one-hot, 1-cycle pulse: transaction aborted on timeout.
- busy  output 1  high while state is GRANT.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state goes to IDLE and the round-robin pointer ptr goes to 0.
  - gnt=0, sel=0, mem_valid=0, ack=0, err=0, busy=0, timeout counter=0.
  - Reset wins over every other event, including reset in the middle of GRANT; no ack or err is issued for the killed transaction.
- All outputs are registered.
- States: IDLE and GRANT.
- IDLE:
  - Form eligible = req & ~mask, where mask is the one-hot of the requester acked or errored in the previous cycle. mask=0 otherwise.
  - Winner is the first set bit of eligible, scanning ptr, ptr+1, ptr+2, ptr+3, modulo 4.
  - If eligible≠0, at the next edge: state goes to GRANT, gnt=onehot(winner), sel=winner, mem_valid=1, busy=1, counter=0.
  - If eligible=0, stay in IDLE.
  - Latency: req high at edge N gives gnt/sel valid after edge N+1. That is 1 cycle in the best case, and 2 cycles right after a completion, because of the turnaround cycle.
- sel holds its last value while in IDLE. It is never changed mid-transaction, so the mux output stays stable for the whole transaction.
- GRANT:
  - req inputs are ignored; the transaction continues even if the granted req drops (protocol violation, not checked).
  - mem_done=1: at the next edge, ack[winner]=1 for one cycle and gnt=0, mem_valid=0, busy=0. State goes to IDLE and ptr = (winner+1) mod 4.
  - mem_done=0 and counter = TIMEOUT-1: at the next edge, err[winner]=1 for one cycle, with the same teardown and ptr update as a completion.
  - mem_done=0 otherwise: counter increments and state stays in GRANT.
  - mem_done and timeout in the same cycle: mem_done wins; ack is issued, err is not.
- Turnaround cycle (the IDLE cycle in which ack or err is high):
  - Arbitration runs in this cycle but masks the finishing requester.
  - So a requester still holding req in its ack cycle is not re-granted immediately.
  - If it still holds req in the following cycle, it is eligible again.
- Fairness: a continuously requesting requester waits at most 3 other transactions.
- mem_done asserted while in IDLE is ignored.
- ack and err are never high together, and never high while gnt≠0.

Test Plan:
- Reset: hold rst=0 for 2 cycles with req=4'b1111 → gnt=0, sel=0, mem_valid=0, ack=0, err=0. Release rst → at the first edge after release, gnt=4'b0001, sel=0.
- Single requester: req=4'b0100 at edge N; mem_done pulses 3 cycles after the grant → gnt=4'b0100 and sel=2 from edge N+1. ack=4'b0100 for exactly one cycle after mem_done. ptr becomes 3.
- Round-robin: req=4'b1111 held, mem_done returned 1 cycle after each grant → grant order 0,1,2,3,0. An idle cycle with gnt=0 appears between grants. sel tracks 0,1,2,3,0.
- Timeout: TIMEOUT=4, req=4'b0010, mem_done held 0 → err=4'b0010 one cycle after the 4th GRANT cycle, no ack, gnt=0. With req still high, requester 1 is re-granted 2 edges after err.
- Simultaneous mem_done and timeout: mem_done=1 exactly in cycle counter=TIMEOUT-1 → ack pulse only, err stays 0.
- Reset mid-GRANT: gnt=4'b1000, rst=0 for 1 cycle before mem_done → no ack/err, all outputs 0. With req=4'b1001 after release, the next grant goes to requester 0.

Source files
------------

// File: rtl/mux4_port_arbiter.sv
// Round-robin arbiter sharing one downstream port among four requesters.
// Drives the 4:1 datapath mux select and runs a valid/done handshake with timeout.
//
// state | meaning
// IDLE  | no transaction; arbitrate among eligible requesters each cycle
// GRANT | one requester owns the port; wait for mem_done or timeout
module mux4_port_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int TW      = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       mem_valid,
    input  logic       mem_done,
    output logic [3:0] ack,
    output logic [3:0] err,
    output logic       busy
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t        state, state_n;
    logic [1:0]    ptr, ptr_n;
    logic [TW-1:0] cnt, cnt_n;
    logic [3:0]    gnt_n, ack_n, err_n;
    logic [1:0]    sel_n;
    logic          mem_valid_n, busy_n;
    logic [3:0]    eligible;
    logic [2:0]    pick;

    // Returns {found, index}; the lowest offset from p wins, so scan downward.
    function automatic logic [2:0] rr_pick(input logic [3:0] elig, input logic [1:0] p);
        logic [2:0] r;
        logic [1:0] k;
        r = '0;
        for (int i = 3; i >= 0; i--) begin
            k = p + 2'(i);
            if (elig[k]) r = {1'b1, k};
        end
        return r;
    endfunction

    // The requester finishing in the turnaround cycle is masked out for one cycle.
    assign eligible = req & ~(ack | err);
    assign pick     = rr_pick(eligible, ptr);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            gnt       <= '0;
            sel       <= '0;
            mem_valid <= 1'b0;
            ack       <= '0;
            err       <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            cnt       <= cnt_n;
            gnt       <= gnt_n;
            sel       <= sel_n;
            mem_valid <= mem_valid_n;
            ack       <= ack_n;
            err       <= err_n;
            busy      <= busy_n;
        end
    end

    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        cnt_n       = cnt;
        gnt_n       = gnt;
        sel_n       = sel;
        mem_valid_n = mem_valid;
        busy_n      = busy;
        ack_n       = '0;
        err_n       = '0;

        case (state)
            IDLE: begin
                if (pick[2]) begin
                    state_n     = GRANT;
                    gnt_n       = 4'b0001 << pick[1:0];
                    sel_n       = pick[1:0];
                    mem_valid_n = 1'b1;
                    busy_n      = 1'b1;
                    cnt_n       = '0;
                end
            end
            GRANT: begin
                if (mem_done || (cnt == TW'(TIMEOUT - 1))) begin
                    if (mem_done) ack_n = gnt;
                    else          err_n = gnt;
                    state_n     = IDLE;
                    gnt_n       = '0;
                    mem_valid_n = 1'b0;
                    busy_n      = 1'b0;
                    ptr_n       = sel + 2'd1;
                end else begin
                    cnt_n = cnt + TW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mux4_port_arbiter.sv
// Directed bench for mux4_port_arbiter: a cycle-by-cycle vector table plus
// a bounded hand-written grant/timeout sequence.
module tb_mux4_port_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       mem_valid;
    logic       mem_done;
    logic [3:0] ack;
    logic [3:0] err;
    logic       busy;

    int errors = 0;
    int checks = 0;

    mux4_port_arbiter #(.TIMEOUT(4), .TW(5)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .sel(sel),
        .mem_valid(mem_valid), .mem_done(mem_done), .ack(ack), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic [3:0] rq;
        logic       d;
        logic [3:0] g;
        logic [1:0] s;
        logic       mv;
        logic [3:0] a;
        logic [3:0] e;
        logic       b;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [3:0] rq, input logic d,
                       input logic [3:0] g, input logic [1:0] s, input logic mv,
                       input logic [3:0] a, input logic [3:0] e, input logic b);
        vec_t v;
        v.r = r; v.rq = rq; v.d = d; v.g = g; v.s = s; v.mv = mv; v.a = a; v.e = e; v.b = b;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got {gnt,sel,mv,ack,err,busy}=%b expected %b", name, got, exp);
        end
    endtask

    initial begin
        int n;
        rst = 1'b0; req = '0; mem_done = 1'b0;

        // rst req done | gnt sel mv ack err busy
        add(0, 4'b1111, 0, 4'b0000, 2'd0, 0, 4'b0000, 4'b0000, 0);  // reset held
        add(0, 4'b1111, 0, 4'b0000, 2'd0, 0, 4'b0000, 4'b0000, 0);
        add(1, 4'b1111, 0, 4'b0001, 2'd0, 1, 4'b0000, 4'b0000, 1);  // first grant after release
        add(1, 4'b1111, 1, 4'b0000, 2'd0, 0, 4'b0001, 4'b0000, 0);  // round robin
        add(1, 4'b1111, 0, 4'b0010, 2'd1, 1, 4'b0000, 4'b0000, 1);
        add(1, 4'b1111, 1, 4'b0000, 2'd1, 0, 4'b0010, 4'b0000, 0);
        add(1, 4'b1111, 0, 4'b0100, 2'd2, 1, 4'b0000, 4'b0000, 1);
        add(1, 4'b1111, 1, 4'b0000, 2'd2, 0, 4'b0100, 4'b0000, 0);
        add(1, 4'b1111, 0, 4'b1000, 2'd3, 1, 4'b0000, 4'b0000, 1);
        add(1, 4'b1111, 1, 4'b0000, 2'd3, 0, 4'b1000, 4'b0000, 0);
        add(1, 4'b1111, 0, 4'b0001, 2'd0, 1, 4'b0000, 4'b0000, 1);
        add(1, 4'b1111, 1, 4'b0000, 2'd0, 0, 4'b0001, 4'b0000, 0);
        add(1, 4'b0100, 0, 4'b0100, 2'd2, 1, 4'b0000, 4'b0000, 1);  // single requester
        add(1, 4'b0100, 0, 4'b0100, 2'd2, 1, 4'b0000, 4'b0000, 1);
        add(1, 4'b0100, 0, 4'b0100, 2'd2, 1, 4'b0000, 4'b0000, 1);
        add(1, 4'b0100, 1, 4'b0000, 2'd2, 0, 4'b0100, 4'b0000, 0);
        add(1, 4'b0000, 0, 4'b0000, 2'd2, 0, 4'b0000, 4'b0000, 0);  // sel holds in IDLE
        add(1, 4'b0000, 1, 4'b0000, 2'd2, 0, 4'b0000, 4'b0000, 0);  // done in IDLE ignored
        add(1, 4'b1001, 0, 4'b1000, 2'd3, 1, 4'b0000, 4'b0000, 1);  // ptr=3 picks requester 3
        add(1, 4'b1001, 0, 4'b1000, 2'd3, 1, 4'b0000, 4'b0000, 1);
        add(1, 4'b1001, 0, 4'b1000, 2'd3, 1, 4'b0000, 4'b0000, 1);
        add(1, 4'b1001, 0, 4'b1000, 2'd3, 1, 4'b0000, 4'b0000, 1);
        add(1, 4'b1001, 1, 4'b0000, 2'd3, 0, 4'b1000, 4'b0000, 0);  // done at terminal count
        add(1, 4'b1001, 0, 4'b0001, 2'd0, 1, 4'b0000, 4'b0000, 1);
        add(1, 4'b1001, 1, 4'b0000, 2'd0, 0, 4'b0001, 4'b0000, 0);
        add(1, 4'b0010, 0, 4'b0010, 2'd1, 1, 4'b0000, 4'b0000, 1);  // timeout run
        add(1, 4'b0010, 0, 4'b0010, 2'd1, 1, 4'b0000, 4'b0000, 1);
        add(1, 4'b0010, 0, 4'b0010, 2'd1, 1, 4'b0000, 4'b0000, 1);
        add(1, 4'b0010, 0, 4'b0010, 2'd1, 1, 4'b0000, 4'b0000, 1);
        add(1, 4'b0010, 0, 4'b0000, 2'd1, 0, 4'b0000, 4'b0010, 0);
        add(1, 4'b0010, 0, 4'b0000, 2'd1, 0, 4'b0000, 4'b0000, 0);  // masked turnaround
        add(1, 4'b0010, 0, 4'b0010, 2'd1, 1, 4'b0000, 4'b0000, 1);
        add(1, 4'b0010, 1, 4'b0000, 2'd1, 0, 4'b0010, 4'b0000, 0);
        add(1, 4'b1000, 0, 4'b1000, 2'd3, 1, 4'b0000, 4'b0000, 1);
        add(0, 4'b1000, 0, 4'b0000, 2'd0, 0, 4'b0000, 4'b0000, 0);  // reset mid-GRANT
        add(1, 4'b1001, 0, 4'b0001, 2'd0, 1, 4'b0000, 4'b0000, 1);
        add(1, 4'b1001, 1, 4'b0000, 2'd0, 0, 4'b0001, 4'b0000, 0);
        add(1, 4'b0100, 0, 4'b0100, 2'd2, 1, 4'b0000, 4'b0000, 1);
        add(1, 4'b0000, 0, 4'b0100, 2'd2, 1, 4'b0000, 4'b0000, 1);  // req drop ignored
        add(1, 4'b0000, 1, 4'b0000, 2'd2, 0, 4'b0100, 4'b0000, 0);

        #2;
        foreach (tbl[i]) begin
            rst = tbl[i].r; req = tbl[i].rq; mem_done = tbl[i].d;
            @(posedge clk); #1;
            check($sformatf("row%0d", i), {gnt, sel, mem_valid, ack, err, busy},
                  {tbl[i].g, tbl[i].s, tbl[i].mv, tbl[i].a, tbl[i].e, tbl[i].b});
        end

        // Grant then run to timeout, with bounded waits.
        rst = 1'b1; req = 4'b0001; mem_done = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (gnt == 4'b0000 && n < 8);
        check("seq_grant", {gnt, sel, mem_valid, ack, err, busy},
              {4'b0001, 2'd0, 1'b1, 4'b0000, 4'b0000, 1'b1});
        n = 1;
        while (err == 4'b0000 && n < 20) begin
            @(posedge clk); #1;
            if (err == 4'b0000) n++;
        end
        check("seq_timeout", {gnt, sel, mem_valid, ack, err, busy},
              {4'b0000, 2'd0, 1'b0, 4'b0000, 4'b0001, 1'b0});
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL seq_grant_cycles: got %0d expected 4", n);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
